i2c_txn_arbiter: RTL
====================

Name: i2c_txn_arbiter

Overview:
Round-robin arbiter and sequencer that shares one AXI-Stream-fed I2C master between NUM_REQ independent requesters. It accepts one single-byte transaction from the winning requester and packs it into one AXIS beat for the master. It then tracks the master until the transaction completes and returns a per-requester response carrying read data and an error flag. It sits between the system-side clients (config FSMs, CPU bridge) and the I2C master.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
I2C_DATA_WIDTH, 8, I2C byte width; addr byte bit 0 is R/W (1 = read, 0 = write).
TIMEOUT_CYCLES, 1024, max clk_i cycles in BUSY before the transaction is aborted as an error.

Ports:
clk_i  in  1  clock.
arstn_i  in  1  reset, asynchronous, active-low.
req_valid_i  in  NUM_REQ  per-requester transaction request.
req_ready_o  out  NUM_REQ  one-hot accept; transfer on valid&ready.
req_addr_i  in  NUM_REQ*8  per-requester {7-bit addr, rw}; slice i = [8i+7:8i].
req_wdata_i  in  NUM_REQ*8  per-requester write byte; ignored for reads.
rsp_valid_o  out  NUM_REQ  one-hot response valid to the granted requester.
rsp_ready_i  in  NUM_REQ  per-requester response accept.
rsp_rdata_o  out  8  read byte; 0 for writes or on error.
rsp_err_o  out  1  1 = timeout, or read completed without a read-data strobe.
m_tvalid_o  out  1  AXIS valid to the I2C master.
m_tready_i  in  1  AXIS ready from the master; high only when the master is idle.
m_tdata_o  out  16  {wdata[7:0], addr[7:0]}.
i2c_rdata_i  in  8  read byte from the master.
rvalid_i  in  1  one-cycle strobe; i2c_rdata_i is valid.
busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 has first priority), all outputs 0, m_tdata_o=0, timeout counter=0, seen_low=0.
- Asserting reset mid-transaction aborts immediately. No response is issued, and the requester must re-request.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - Grant is combinational: the first asserted req_valid_i scanning from rr_ptr+1 upward, with wrap-around mod NUM_REQ.
  - req_ready_o = one-hot grant; it is only ever nonzero in IDLE.
  - On transfer: latch grant index, addr and wdata into registers. Next state ISSUE.
  - With no request, stay in IDLE with all outputs 0.
- ISSUE:
  - m_tvalid_o=1. m_tdata_o is driven from the latched registers and held stable until the handshake.
  - On m_tvalid_o&m_tready_i: go to BUSY, clear the timeout counter, clear seen_low.
  - ISSUE has no timeout; a master that never becomes ready stalls here.
- BUSY:
  - m_tvalid_o=0. Set seen_low when m_tready_i=0.
  - On rvalid_i, capture i2c_rdata_i into rdata_reg. rvalid_i outside BUSY is ignored.
  - Completion occurs when seen_low=1 and m_tready_i=1. The master deasserting then reasserting ready marks the end of the transaction. Go to RESP.
  - err = read && no rvalid_i seen.
  - The counter increments every BUSY cycle. If it reaches TIMEOUT_CYCLES-1 before completion, go to RESP with err=1 and rdata=0.
  - If completion and timeout occur in the same cycle, completion wins (err follows the read rule only).
- RESP:
  - rsp_valid_o[grant]=1; rsp_rdata_o and rsp_err_o are held stable.
  - When rsp_ready_i[grant]=1: go to IDLE and set rr_ptr=grant. The new arbitration happens in the following cycle, so there is no back-to-back IDLE bypass.
- Latency: request accept to m_tvalid_o is 1 cycle. BUSY to RESP is 1 cycle after completion is detected.
- Minimum spacing between grants is 4 cycles plus master time.
- Fairness: a requester holding valid continuously is served at most once per NUM_REQ grants while others are pending.
- Requester rules: a requester must hold addr and wdata stable while valid. Dropping valid before ready is permitted and loses nothing.

Test Plan:
- Single write: req 1 issues addr=0xA0, wdata=0x5C. Required: m_tdata_o=0x5CA0 one cycle after accept; master ready goes low then high; rsp_valid_o=0b0010, rsp_err_o=0, rsp_rdata_o=0x00.
- Single read: req 2 issues addr=0xA1; master pulses rvalid_i with 0x3E before ready returns. Required: rsp_valid_o=0b0100, rsp_rdata_o=0x3E, rsp_err_o=0.
- Round-robin: all 4 requesters hold valid from reset. Required: grant order 0,1,2,3,0. Then with req 0 and req 3 pending after last grant 0, the next grant is 3.
- Timeout: master accepts the beat and then holds m_tready_i=0 indefinitely. Required: RESP entered after 1024 BUSY cycles, rsp_err_o=1, rsp_rdata_o=0.
- Read with missing strobe: read completes with no rvalid_i pulse. Required: rsp_err_o=1. In the same scenario, an rsp_ready_i stall of 10 cycles keeps rsp_valid_o and rsp_rdata_o stable.
- Reset mid-BUSY: assert arstn_i low during a read. Required: all outputs 0 immediately; after release, req 0 wins first arbitration.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one AXIS-fed I2C master between NUM_REQ requesters,
// issuing one single-byte transaction at a time and returning a per-requester response.
module i2c_txn_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int I2C_DATA_WIDTH = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                clk_i,
   input  logic                                arstn_i,
   input  logic [NUM_REQ-1:0]                  req_valid_i,
   output logic [NUM_REQ-1:0]                  req_ready_o,
   input  logic [NUM_REQ*I2C_DATA_WIDTH-1:0]   req_addr_i,
   input  logic [NUM_REQ*I2C_DATA_WIDTH-1:0]   req_wdata_i,
   output logic [NUM_REQ-1:0]                  rsp_valid_o,
   input  logic [NUM_REQ-1:0]                  rsp_ready_i,
   output logic [I2C_DATA_WIDTH-1:0]           rsp_rdata_o,
   output logic                                rsp_err_o,
   output logic                                m_tvalid_o,
   input  logic                                m_tready_i,
   output logic [2*I2C_DATA_WIDTH-1:0]         m_tdata_o,
   input  logic [I2C_DATA_WIDTH-1:0]           i2c_rdata_i,
   input  logic                                rvalid_i,
   output logic                                busy_o
);
   localparam int DW = I2C_DATA_WIDTH;
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]   arb_idx, scan_idx;
   logic            arb_hit;
   logic [DW-1:0]   addr_sel, wdata_sel;
   logic [DW-1:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic            rd_seen_q, rd_seen_d, seen_low_q, seen_low_d, err_q, err_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done, tmo, got_rd;

   // Scan from the requester after the last winner, wrapping around.
   always_comb begin
      arb_hit  = 1'b0;
      arb_idx  = '0;
      scan_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!arb_hit && req_valid_i[scan_idx]) begin
            arb_hit = 1'b1;
            arb_idx = scan_idx;
         end
      end
   end

   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IW'(i) == arb_idx) begin
            addr_sel  = req_addr_i[i*DW +: DW];
            wdata_sel = req_wdata_i[i*DW +: DW];
         end
      end
   end

   assign done   = (state_q == S_BUSY) && seen_low_q && m_tready_i;
   assign tmo    = (state_q == S_BUSY) && (cnt_q == CNT_LAST);
   assign got_rd = rd_seen_q | rvalid_i;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_d      = gnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      rd_seen_d  = rd_seen_q;
      seen_low_d = seen_low_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (arb_hit) begin
               gnt_d   = arb_idx;
               addr_d  = addr_sel;
               wdata_d = wdata_sel;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (m_tready_i) begin
               cnt_d      = '0;
               seen_low_d = 1'b0;
               rd_seen_d  = 1'b0;
               rdata_d    = '0;
               state_d    = S_BUSY;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (!m_tready_i) seen_low_d = 1'b1;
            if (rvalid_i) begin
               rdata_d   = i2c_rdata_i;
               rd_seen_d = 1'b1;
            end
            // Completion outranks a coincident timeout.
            if (done) begin
               err_d   = addr_q[0] & ~got_rd;
               rdata_d = (addr_q[0] && got_rd) ? (rvalid_i ? i2c_rdata_i : rdata_q) : '0;
               state_d = S_RESP;
            end else if (tmo) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready_i[gnt_q]) begin
               rr_ptr_d = gnt_q;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      rsp_rdata_o = '0;
      rsp_err_o   = 1'b0;
      m_tvalid_o  = 1'b0;
      m_tdata_o   = '0;
      busy_o      = (state_q != S_IDLE);
      case (state_q)
         S_IDLE:  if (arb_hit && arstn_i) req_ready_o = NUM_REQ'(1) << arb_idx;
         S_ISSUE: begin
            m_tvalid_o = 1'b1;
            m_tdata_o  = {wdata_q, addr_q};
         end
         S_RESP: begin
            rsp_valid_o = NUM_REQ'(1) << gnt_q;
            rsp_rdata_o = rdata_q;
            rsp_err_o   = err_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= IW'(NUM_REQ - 1);
         gnt_q      <= '0;
         rd_seen_q  <= 1'b0;
         seen_low_q <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_q      <= gnt_d;
         rd_seen_q  <= rd_seen_d;
         seen_low_q <= seen_low_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   // Payload registers are only observed through state-gated outputs.
   always_ff @(posedge clk_i) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
   end
endmodule
